// File: rtl/jk_cmd_sequencer.sv
// Command FIFO feeding a J/K drive sequencer, with a built-in reference model of the
// downstream JK flip-flop and a sticky disagreement flag.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic             j,
  output logic             k,
  input  logic             yout,
  output logic             busy,
  output logic             q_model,
  output logic             model_valid,
  output logic             mismatch
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [1:0]       op_mem  [DEPTH];
  logic [CNT_W-1:0] rep_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [CNT_W-1:0] counter;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != FULL_CNT);
  assign push       = rst_n && cmd_valid && cmd_ready;
  // The executor takes the head whenever it is idle or its current command has run out.
  assign pop        = !fifo_empty && ((state == IDLE) || (counter == '0));
  assign busy       = (state == RUN) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= cmd_op;
      rep_mem[wr_ptr] <= cmd_rep;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      j       <= 1'b0;
      k       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            {j, k}  <= op_mem[rd_ptr];
            counter <= rep_mem[rd_ptr];
            state   <= RUN;
          end else begin
            j <= 1'b0;
            k <= 1'b0;
          end
        end
        RUN: begin
          if (counter != '0) begin
            counter <= counter - CNT_W'(1);
          end else if (!fifo_empty) begin
            {j, k}  <= op_mem[rd_ptr];
            counter <= rep_mem[rd_ptr];
          end else begin
            j     <= 1'b0;
            k     <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The check uses q_model and model_valid as they stood before this edge's update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_model     <= 1'b0;
      model_valid <= 1'b0;
      mismatch    <= 1'b0;
    end else begin
      if (model_valid && (yout != q_model)) mismatch <= 1'b1;
      if (j ^ k) model_valid <= 1'b1;
      case ({j, k})
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: q_model <= q_model;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench: a queue-based behavioural model is compared with the DUT on every
// negative clock edge, and directed scenarios pin the model with hand-computed literals.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  typedef struct {
    logic [1:0]       op;
    logic [CNT_W-1:0] rep;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_rep = '0;
  logic             cmd_ready, j, k, busy, q_model, model_valid, mismatch;
  logic             q_ff = 1'b0;
  logic             inject = 1'b0;
  logic             yout;

  int assert_count = 0;
  int fail_count   = 0;
  bit checking     = 1'b0;

  // Behavioural model state: pending commands, the running command and its remaining cycles.
  cmd_t       mq[$];
  bit         m_active = 1'b0;
  logic [1:0] m_op = 2'b00;
  int         m_left = 0;
  logic       m_q = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_mis = 1'b0;

  assign yout = q_ff ^ inject;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rep(cmd_rep), .j(j), .k(k), .yout(yout), .busy(busy),
    .q_model(q_model), .model_valid(model_valid), .mismatch(mismatch)
  );

  // A real downstream JK flip-flop closing the loop through yout.
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: ;
    endcase
  end

  always @(posedge clk) begin
    logic [1:0] jk_now;
    int         size_before;
    cmd_t       c;
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      m_op     = 2'b00;
      m_left   = 0;
      m_q      = 1'b0;
      m_valid  = 1'b0;
      m_mis    = 1'b0;
    end else begin
      jk_now = m_active ? m_op : 2'b00;
      if (m_valid && (yout !== m_q)) m_mis = 1'b1;
      if (jk_now == 2'b01) m_q = 1'b0;
      else if (jk_now == 2'b10) m_q = 1'b1;
      else if (jk_now == 2'b11) m_q = ~m_q;
      if (jk_now == 2'b01 || jk_now == 2'b10) m_valid = 1'b1;
      size_before = mq.size();
      if (m_active && m_left > 1) begin
        m_left = m_left - 1;
      end else if (mq.size() != 0) begin
        c        = mq.pop_front();
        m_op     = c.op;
        m_left   = int'(c.rep) + 1;
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
      end
      if (cmd_valid && size_before < DEPTH) begin
        c.op  = cmd_op;
        c.rep = cmd_rep;
        mq.push_back(c);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_j", 32'(j), 32'(m_active && m_op[1]));
      checkOutput("model_k", 32'(k), 32'(m_active && m_op[0]));
      checkOutput("model_busy", 32'(busy), 32'(m_active || mq.size() != 0));
      checkOutput("model_ready", 32'(cmd_ready), 32'(mq.size() != DEPTH));
      checkOutput("model_q", 32'(q_model), 32'(m_q));
      checkOutput("model_valid", 32'(model_valid), 32'(m_valid));
      checkOutput("model_mismatch", 32'(mismatch), 32'(m_mis));
    end
  end

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] rep);
    cmd_valid = v;
    cmd_op    = op;
    cmd_rep   = rep;
    @(posedge clk);
    #2;
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'b00, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] seq033 [6];
    logic [1:0] seq034 [5];
    seq033 = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    seq034 = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00};

    rst_n = 1'b0;
    applyStimulus(1'b0, 2'b00, '0);
    applyStimulus(1'b0, 2'b00, '0);
    checking = 1'b1;
    checkOutput("rst_j", 32'(j), 0);
    checkOutput("rst_k", 32'(k), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_ready", 32'(cmd_ready), 1);
    checkOutput("rst_valid", 32'(model_valid), 0);
    checkOutput("rst_mismatch", 32'(mismatch), 0);
    rst_n = 1'b1;

    // Single set command held for three cycles.
    applyStimulus(1'b1, 2'b10, 4'd2);
    checkOutput("set_e0_j", 32'(j), 0);
    checkOutput("set_e0_busy", 32'(busy), 1);
    for (int e = 1; e <= 3; e++) begin
      applyStimulus(1'b0, 2'b00, '0);
      checkOutput("set_run_jk", 32'({j, k}), 32'(2'b10));
    end
    applyStimulus(1'b0, 2'b00, '0);
    checkOutput("set_end_jk", 32'({j, k}), 0);
    checkOutput("set_end_busy", 32'(busy), 0);
    checkOutput("set_end_q", 32'(q_model), 1);
    checkOutput("set_end_valid", 32'(model_valid), 1);
    checkOutput("set_end_model_q", 32'(m_q), 1);

    // Back-to-back commands with no bubble.
    applyStimulus(1'b1, 2'b10, 4'd0);
    checkOutput("b2b_jk", 32'({j, k}), 32'(seq033[0]));
    applyStimulus(1'b1, 2'b11, 4'd1);
    checkOutput("b2b_jk", 32'({j, k}), 32'(seq033[1]));
    applyStimulus(1'b1, 2'b01, 4'd0);
    checkOutput("b2b_jk", 32'({j, k}), 32'(seq033[2]));
    for (int e = 3; e < 6; e++) begin
      applyStimulus(1'b0, 2'b00, '0);
      checkOutput("b2b_jk", 32'({j, k}), 32'(seq033[e]));
    end

    // Fill the FIFO behind a long hold command.
    applyStimulus(1'b1, 2'b00, 4'd15);
    applyStimulus(1'b0, 2'b00, '0);
    applyStimulus(1'b1, 2'b10, 4'd0);
    checkOutput("full_ready1", 32'(cmd_ready), 1);
    applyStimulus(1'b1, 2'b01, 4'd0);
    checkOutput("full_ready2", 32'(cmd_ready), 1);
    applyStimulus(1'b1, 2'b11, 4'd0);
    checkOutput("full_ready3", 32'(cmd_ready), 1);
    applyStimulus(1'b1, 2'b10, 4'd0);
    checkOutput("full_ready4", 32'(cmd_ready), 0);
    applyStimulus(1'b1, 2'b01, 4'd3);
    checkOutput("full_ready5", 32'(cmd_ready), 0);
    for (int e = 7; e <= 16; e++) applyStimulus(1'b0, 2'b00, '0);
    checkOutput("full_hold_ready", 32'(cmd_ready), 0);
    checkOutput("full_hold_jk", 32'({j, k}), 0);
    checkOutput("full_hold_busy", 32'(busy), 1);
    for (int e = 0; e < 5; e++) begin
      applyStimulus(1'b0, 2'b00, '0);
      if (e == 0) checkOutput("full_ready_back", 32'(cmd_ready), 1);
      checkOutput("full_drain_jk", 32'({j, k}), 32'(seq034[e]));
    end
    checkOutput("full_drain_busy", 32'(busy), 0);

    // Set then three toggles tracked by the real flip-flop, then one corrupted sample.
    applyStimulus(1'b1, 2'b10, 4'd0);
    applyStimulus(1'b1, 2'b11, 4'd2);
    for (int e = 0; e < 5; e++) applyStimulus(1'b0, 2'b00, '0);
    checkOutput("chk_clean", 32'(mismatch), 0);
    checkOutput("chk_q", 32'(q_model), 0);
    inject = 1'b1;
    applyStimulus(1'b0, 2'b00, '0);
    inject = 1'b0;
    checkOutput("chk_hit", 32'(mismatch), 1);
    for (int e = 0; e < 3; e++) applyStimulus(1'b0, 2'b00, '0);
    checkOutput("chk_sticky", 32'(mismatch), 1);

    // Toggles alone never make the model known.
    resetPulse();
    applyStimulus(1'b1, 2'b11, 4'd3);
    for (int e = 0; e < 7; e++) begin
      inject = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, 2'b00, '0);
      checkOutput("tgl_valid", 32'(model_valid), 0);
      checkOutput("tgl_mismatch", 32'(mismatch), 0);
    end
    inject = 1'b0;

    // Reset while the first of three queued commands runs, with cmd_valid held high.
    resetPulse();
    applyStimulus(1'b1, 2'b10, 4'd3);
    applyStimulus(1'b1, 2'b01, 4'd3);
    applyStimulus(1'b1, 2'b11, 4'd3);
    checkOutput("abort_pre_j", 32'(j), 1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 2'b10, 4'd1);
    rst_n = 1'b1;
    checkOutput("abort_jk", 32'({j, k}), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_ready", 32'(cmd_ready), 1);
    checkOutput("abort_mismatch", 32'(mismatch), 0);
    for (int e = 0; e < 6; e++) begin
      applyStimulus(1'b0, 2'b00, '0);
      checkOutput("abort_quiet_jk", 32'({j, k}), 0);
      checkOutput("abort_quiet_busy", 32'(busy), 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      inject = ($urandom_range(0, 199) == 0);
      applyStimulus(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 15))
                                                : CNT_W'($urandom_range(0, 3)));
    end
    rst_n     = 1'b1;
    inject    = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    checking = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
